// File: rtl/laplace_pkg.sv
// Shared types and constants for the Laplace window generator.
// The optional framing check in laplace_window_gen is enabled by WIN_FRAME_CHECK_EN.
package laplace_pkg;

    localparam int PIX_W         = 8;
    localparam int IMG_W_DEFAULT = 640;
    localparam int IMG_H_DEFAULT = 480;

    typedef struct packed {
        logic [PIX_W-1:0] b;
        logic [PIX_W-1:0] d;
        logic [PIX_W-1:0] e;
        logic [PIX_W-1:0] f;
        logic [PIX_W-1:0] h;
    } window_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage: combinational read, synchronous write, shared index.
module line_buffer
    import laplace_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wr_data,
    output logic [PIX_W-1:0] rd_data
);

    // Contents are never reset; every location is rewritten before it can reach a window.
    logic [PIX_W-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/laplace_window_gen.sv
// Streams raster pixels through two row buffers and emits one registered b/d/e/f/h cross per interior centre.
// Define WIN_FRAME_CHECK_EN to enable the sticky frame_err framing check; otherwise frame_err is tied low.
module laplace_window_gen
    import laplace_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] d,
    output logic [PIX_W-1:0] e,
    output logic [PIX_W-1:0] f,
    output logic [PIX_W-1:0] h,
    output logic             out_last,
    output logic             frame_err
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0]    x_q, x_d, cur_x;
    logic [YW-1:0]    y_q, y_d, cur_y;
    logic [PIX_W-1:0] mid0_q, mid0_d, mid1_q, mid1_d, mid2_q, mid2_d;
    logic [PIX_W-1:0] top_q, top_d, bot_q, bot_d;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    window_t          win_q, win_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             accept, emit;

    // Handshake: a pixel transfers on in_valid && in_ready, a window on out_valid && out_ready;
    // the single output register may be refilled in the same cycle it is consumed.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign cur_x    = in_sof ? '0 : x_q;
    assign cur_y    = in_sof ? '0 : y_q;
    assign emit     = accept && (cur_x >= XW'(2)) && (cur_y >= YW'(2));

    line_buffer #(.DEPTH(IMG_W), .AW(XW)) u_lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (cur_x),
        .wr_data (lb1_rd),
        .rd_data (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .AW(XW)) u_lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (cur_x),
        .wr_data (in_pixel),
        .rd_data (lb1_rd)
    );

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        mid0_d      = mid0_q;
        mid1_d      = mid1_q;
        mid2_d      = mid2_q;
        top_d       = top_q;
        bot_d       = bot_q;
        win_d       = win_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (accept) begin
            if (cur_x == X_LAST) begin
                x_d = '0;
                y_d = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
                y_d = cur_y;
            end
            mid0_d = lb1_rd;
            mid1_d = mid0_q;
            mid2_d = mid1_q;
            top_d  = lb0_rd;
            bot_d  = in_pixel;
        end

        // Centre is column x-1: its top and bottom are the taps captured one pixel ago,
        // and its right neighbour is the row y-1 value being read right now.
        if (emit) begin
            win_d.b     = top_q;
            win_d.d     = mid1_q;
            win_d.e     = mid0_q;
            win_d.f     = lb1_rd;
            win_d.h     = bot_q;
            out_last_d  = (cur_x == X_LAST) && (cur_y == Y_LAST);
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            mid0_q      <= '0;
            mid1_q      <= '0;
            mid2_q      <= '0;
            top_q       <= '0;
            bot_q       <= '0;
            win_q       <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            mid0_q      <= mid0_d;
            mid1_q      <= mid1_d;
            mid2_q      <= mid2_d;
            top_q       <= top_d;
            bot_q       <= bot_d;
            win_q       <= win_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign b         = win_q.b;
    assign d         = win_q.d;
    assign e         = win_q.e;
    assign f         = win_q.f;
    assign h         = win_q.h;

`ifdef WIN_FRAME_CHECK_EN
    logic err_q, err_d, first_q, first_d;

    // The very first pixel after reset may omit in_sof without being flagged.
    always_comb begin
        err_d   = err_q;
        first_d = first_q;
        if (accept) begin
            first_d = 1'b0;
            if (in_sof && ((x_q != '0) || (y_q != '0))) begin
                err_d = 1'b1;
            end
            if (!in_sof && (x_q == '0) && (y_q == '0) && !first_q) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            first_q <= 1'b1;
        end else begin
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_laplace_window_gen.sv
// Self-checking bench for laplace_window_gen on a 4x4 image: spec-level frame model plus directed cases.
module tb_laplace_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WW = 41;  // {out_last, b, d, e, f, h}
`ifdef WIN_FRAME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, in_ready, in_sof = 1'b0, out_valid, out_ready, out_last, frame_err;
  logic [7:0] in_pixel = '0, b, d, e, f, h;

  laplace_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready), .b(b), .d(d), .e(e),
    .f(f), .h(h), .out_last(out_last), .frame_err(frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: reference model of the frame
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] seen_q[$];
  logic [7:0]    img[H][W];
  int            pos = 0;
  bit            m_err = 1'b0, m_first = 1'b1;
  int            windows_seen = 0;
  logic [WW-1:0] held, got, expv;
  bit            held_valid = 1'b0;
  int            px, py;

  always @(negedge clk) begin
    got = {out_last, b, d, e, f, h};
    if (rst) begin
      exp_q.delete();
      pos = 0; m_err = 1'b0; m_first = 1'b1; held_valid = 1'b0;
    end else begin
      check("frame_err", frame_err, CHK ? m_err : 1'b0);
      if (out_valid && !out_ready) begin
        check("in_ready_hold", in_ready, 1'b0);
        if (held_valid) check("hold_stable", got, held);
        held = got; held_valid = 1'b1;
      end else begin
        held_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_window", got, '0);
        end else begin
          expv = exp_q.pop_front();
          check("window", got, expv);
        end
        windows_seen++;
        seen_q.push_back(got);
      end
      if (in_valid && in_ready) begin
        if (in_sof && pos != 0) m_err = 1'b1;
        if (!in_sof && pos == 0 && !m_first) m_err = 1'b1;
        m_first = 1'b0;
        if (in_sof) pos = 0;
        px = pos % W; py = pos / W;
        img[py][px] = in_pixel;
        if (px >= 2 && py >= 2)
          exp_q.push_back({(pos == W*H-1), img[py-2][px-1], img[py-1][px-2],
                           img[py-1][px-1], img[py-1][px], img[py][px-1]});
        pos = (pos + 1) % (W*H);
      end
    end
  end

  // consumer: 0 always ready, 1 random, 2 stall 3 cycles on first window, 3 never ready
  int ready_mode = 0;
  int stall_cnt  = 0;
  bit stall_done = 1'b0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (out_valid && !stall_done) begin stall_done = 1'b1; stall_cnt = 3; end
          if (stall_cnt > 0) begin out_ready = 1'b0; stall_cnt--; end
          else out_ready = 1'b1;
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // driver tasks: all start and end just after a rising edge
  task automatic send_pixel(input logic [7:0] pix, input logic sof);
    int guard = 0;
    in_valid = 1'b1; in_pixel = pix; in_sof = sof;
    @(negedge clk);
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) check("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_range(input int from, input int to, input bit rnd, input bit sof_first, input int gap_max);
    for (int p = from; p <= to; p++) begin
      send_pixel(rnd ? 8'($urandom_range(0, 255)) : 8'(4*(p/W) + (p%W) + 1), sof_first && p == from);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic wait_drain(input string tag, input int start, input int exp_cnt);
    int cnt = 0;
    while ((exp_q.size() != 0 || out_valid) && cnt < 300) begin @(negedge clk); cnt++; end
    check({tag, "_drain_timeout"}, cnt < 300, 1'b1);
    @(posedge clk); #1;
    check({tag, "_count"}, windows_seen - start, exp_cnt);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sof = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [WW-1:0] ref_tab[4];
  int            start, lasts;

  initial begin
    ref_tab[0] = {1'b0, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10};
    ref_tab[1] = {1'b0, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11};
    ref_tab[2] = {1'b0, 8'd6, 8'd9, 8'd10, 8'd11, 8'd14};
    ref_tab[3] = {1'b1, 8'd7, 8'd10, 8'd11, 8'd12, 8'd15};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_window", {out_last, b, d, e, f, h}, '0);
    @(posedge clk); #1;

    // basic frame
    seen_q.delete(); start = windows_seen;
    send_range(0, 15, 1'b0, 1'b1, 0);
    wait_drain("basic", start, 4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++) check("basic_tab", seen_q[i], ref_tab[i]);

    // backpressure on first window
    ready_mode = 2; stall_done = 1'b0;
    seen_q.delete(); start = windows_seen;
    send_range(0, 15, 1'b0, 1'b1, 0);
    wait_drain("stall", start, 4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++) check("stall_tab", seen_q[i], ref_tab[i]);
    ready_mode = 0;

    // two back-to-back frames
    seen_q.delete(); start = windows_seen;
    send_range(0, 15, 1'b0, 1'b1, 0);
    send_range(0, 15, 1'b0, 1'b1, 0);
    wait_drain("b2b", start, 8);
    lasts = 0;
    for (int i = 0; i < seen_q.size(); i++) begin
      check("b2b_tab", seen_q[i], ref_tab[i % 4]);
      lasts += int'(seen_q[i][WW-1]);
    end
    check("b2b_lasts", lasts, 2);

    // in_sof on the 7th pixel resyncs the frame
    seen_q.delete(); start = windows_seen;
    send_range(0, 5, 1'b0, 1'b1, 0);
    check("pre_sof_err", frame_err, 1'b0);
    send_pixel(8'd1, 1'b1);
    check("mid_sof_err", frame_err, CHK);
    send_range(1, 15, 1'b0, 1'b0, 0);
    wait_drain("resync", start, 4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++) check("resync_tab", seen_q[i], ref_tab[i]);

    // reset mid-frame with a window pending
    ready_mode = 3;
    send_range(0, 10, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("pending_before_rst", out_valid, 1'b1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("rst_drop_valid", out_valid, 1'b0);
    check("rst_clear_err", frame_err, 1'b0);
    @(posedge clk); #1;
    ready_mode = 0;
    seen_q.delete(); start = windows_seen;
    send_range(0, 15, 1'b0, 1'b0, 0);  // first pixel after reset without in_sof
    wait_drain("after_rst", start, 4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++) check("after_rst_tab", seen_q[i], ref_tab[i]);
    check("first_no_sof_err", frame_err, 1'b0);

    // random pixels, random gaps and backpressure
    ready_mode = 1;
    start = windows_seen;
    for (int fr = 0; fr < 3; fr++) send_range(0, 15, 1'b1, 1'b1, 2);
    ready_mode = 0;
    wait_drain("random", start, 12);
    check("random_err", frame_err, 1'b0);

    // a later frame starting without in_sof is a framing error
    start = windows_seen;
    send_range(0, 15, 1'b1, 1'b0, 0);
    wait_drain("no_sof", start, 4);
    check("no_sof_err", frame_err, CHK);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
